// File: rtl/bf_pkg.sv
// bf_pkg: shared definitions for the bf_core Brainfuck execution core.
//   - ASCII opcode values
//   - core FSM state encoding
//   - fault cause codes (why the core ended up in FAULT)
package bf_pkg;

  localparam logic [7:0] OP_INC   = 8'h2B; // +
  localparam logic [7:0] OP_DEC   = 8'h2D; // -
  localparam logic [7:0] OP_RIGHT = 8'h3E; // >
  localparam logic [7:0] OP_LEFT  = 8'h3C; // <
  localparam logic [7:0] OP_OUT   = 8'h2E; // .
  localparam logic [7:0] OP_IN    = 8'h2C; // ,
  localparam logic [7:0] OP_LOOP  = 8'h5B; // [
  localparam logic [7:0] OP_END   = 8'h5D; // ]
  localparam logic [7:0] OP_HALT  = 8'h00;

  typedef enum logic [3:0] {
    RESET_LOAD,
    FETCH,
    EXEC,
    LOAD,
    SKIP,
    SCAN_BACK,
    IN_WAIT,
    OUT_WAIT,
    HALT,
    FAULT
  } bf_state_e;

  typedef enum logic [2:0] {
    FC_NONE,
    FC_OVERFLOW,   // '[' push with the return stack full
    FC_UNDERFLOW,  // ']' with the return stack empty
    FC_SKIP_EOF,   // 0x00 reached while skipping forward
    FC_SCAN_BOF    // backward scan walked past address 0
  } bf_fault_e;

endpackage

// File: rtl/bf_loop_stack.sv
// bf_loop_stack: LIFO of loop return addresses ('[' positions).
// Ports:
//   clk, rst      clock, synchronous active-high reset (empties the stack)
//   push_i, din_i push din_i (ignored when full)
//   pop_i         drop the top entry (ignored when empty)
//   top_o         current top entry (undefined while empty)
//   full_o        DEPTH entries held
//   empty_o       no entries held
module bf_loop_stack #(
  parameter int DEPTH = 16,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] top_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] top_idx;

  assign top_idx = cnt_q - 1'b1;
  assign top_o   = mem_q[top_idx[IW-1:0]];
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (push_i && !full_o) begin
      mem_q[cnt_q[IW-1:0]] <= din_i;
      cnt_q                <= cnt_q + 1'b1;
    end else if (pop_i && !empty_o) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/bf_core.sv
// bf_core: Brainfuck execution core with separate instruction and data ports
// and valid/ready byte streams for '.' and ','.
//
// Build option: BF_LOOP_STACK_EN
//   defined   - ']' jumps back in one cycle through bf_loop_stack; stack
//               overflow/underflow are faults.
//   undefined - no stack; a taken ']' walks pc backwards (SCAN_BACK) to the
//               matching '['; walking past address 0 is a fault.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   ix_addr / ix_data     instruction fetch (data one cycle after address)
//   dt_addr / dt_rdata    data read (data one cycle after address)
//   dt_we / dt_wdata      data write-through of the cached cell
//   in_*                  input byte stream (core is the sink)
//   out_*                 output byte stream (core is the source)
//   pcout, dcout          debug copies of pc and dc
//   halted, error         stopped / stopped because of a fault
module bf_core
  import bf_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 16,
  parameter int                STACK_DEPTH = 16,
  parameter logic [ADDR_W-1:0] DC_BASE     = ADDR_W'(16'h0100)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] ix_addr,
  input  logic [7:0]        ix_data,
  output logic [ADDR_W-1:0] dt_addr,
  output logic              dt_we,
  output logic [DATA_W-1:0] dt_wdata,
  input  logic [DATA_W-1:0] dt_rdata,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] pcout,
  output logic [ADDR_W-1:0] dcout,
  output logic              halted,
  output logic              error
);

  localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
  localparam logic [DATA_W-1:0] D_ONE = DATA_W'(1);

  bf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] dc_q, dc_d;
  logic [DATA_W-1:0] dt_q, dt_d;
  logic [ADDR_W-1:0] depth_q, depth_d;    // bracket nesting while skipping/scanning
  logic              ph_q, ph_d;          // SKIP/SCAN_BACK: 0 = address out, 1 = byte in
  logic              refill_q, refill_d;  // dt_rdata holds the new cell this FETCH
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0] pc_inc;
  logic              dt_zero;
  bf_fault_e         fault;

`ifdef BF_LOOP_STACK_EN
  logic              st_push, st_pop, st_full, st_empty;
  logic [ADDR_W-1:0] st_top;

  bf_loop_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (ADDR_W)
  ) u_stack (
    .clk     (clk),
    .rst     (rst),
    .push_i  (st_push),
    .pop_i   (st_pop),
    .din_i   (pc_q),
    .top_o   (st_top),
    .full_o  (st_full),
    .empty_o (st_empty)
  );
`else
  // Address of the ']' that started a backward scan; pc is restored to it
  // if the scan runs off the start of program memory.
  logic [ADDR_W-1:0] ret_q, ret_d;
`endif

  assign pc_inc  = pc_q + A_ONE;
  assign dt_zero = (dt_q == '0);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    dc_d        = dc_q;
    dt_d        = dt_q;
    depth_d     = depth_q;
    ph_d        = ph_q;
    refill_d    = refill_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    dt_we       = 1'b0;
    dt_wdata    = dt_q;
    fault       = FC_NONE;
`ifdef BF_LOOP_STACK_EN
    st_push     = 1'b0;
    st_pop      = 1'b0;
`else
    ret_d       = ret_q;
`endif

    case (state_q)
      // The read of DC_BASE issued here (and in LOAD) returns during the
      // following FETCH, which is where dt picks it up.
      RESET_LOAD: begin
        refill_d = 1'b1;
        state_d  = FETCH;
      end

      FETCH: begin
        if (refill_q) dt_d = dt_rdata;
        refill_d = 1'b0;
        state_d  = EXEC;
      end

      EXEC: begin
        state_d = FETCH;
        pc_d    = pc_inc;
        case (ix_data)
          OP_INC: begin
            dt_d     = dt_q + D_ONE;
            dt_we    = 1'b1;
            dt_wdata = dt_q + D_ONE;
          end
          OP_DEC: begin
            dt_d     = dt_q - D_ONE;
            dt_we    = 1'b1;
            dt_wdata = dt_q - D_ONE;
          end
          OP_RIGHT: begin
            dc_d    = dc_q + A_ONE;
            state_d = LOAD;
          end
          OP_LEFT: begin
            dc_d    = dc_q - A_ONE;
            state_d = LOAD;
          end
          OP_OUT: begin
            out_valid_d = 1'b1;
            out_data_d  = dt_q;
            state_d     = OUT_WAIT;
          end
          OP_IN: state_d = IN_WAIT;
          OP_LOOP: begin
            if (dt_zero) begin
              depth_d = A_ONE;
              ph_d    = 1'b0;
              state_d = SKIP;
            end else begin
`ifdef BF_LOOP_STACK_EN
              if (st_full) begin
                pc_d  = pc_q;
                fault = FC_OVERFLOW;
              end else begin
                st_push = 1'b1;
              end
`endif
            end
          end
          OP_END: begin
`ifdef BF_LOOP_STACK_EN
            if (st_empty) begin
              pc_d  = pc_q;
              fault = FC_UNDERFLOW;
            end else if (!dt_zero) begin
              pc_d = st_top + A_ONE;
            end else begin
              st_pop = 1'b1;
            end
`else
            if (!dt_zero) begin
              if (pc_q == '0) begin
                pc_d  = pc_q;
                fault = FC_SCAN_BOF;
              end else begin
                ret_d   = pc_q;
                pc_d    = pc_q - A_ONE;
                depth_d = A_ONE;
                ph_d    = 1'b0;
                state_d = SCAN_BACK;
              end
            end
`endif
          end
          OP_HALT: begin
            pc_d    = pc_q;
            state_d = HALT;
          end
          default: ;
        endcase
      end

      LOAD: begin
        refill_d = 1'b1;
        state_d  = FETCH;
      end

      SKIP: begin
        if (!ph_q) begin
          ph_d = 1'b1;
        end else begin
          ph_d = 1'b0;
          pc_d = pc_inc;
          case (ix_data)
            OP_LOOP: depth_d = depth_q + A_ONE;
            OP_END: begin
              depth_d = depth_q - A_ONE;
              if (depth_q == A_ONE) state_d = FETCH;
            end
            OP_HALT: begin
              pc_d  = pc_q;
              fault = FC_SKIP_EOF;
            end
            default: ;
          endcase
        end
      end

`ifndef BF_LOOP_STACK_EN
      SCAN_BACK: begin
        if (!ph_q) begin
          ph_d = 1'b1;
        end else begin
          ph_d = 1'b0;
          if (ix_data == OP_LOOP && depth_q == A_ONE) begin
            // Matching '[' found: resume just after it, as a stack jump would.
            depth_d = '0;
            pc_d    = pc_inc;
            state_d = FETCH;
          end else begin
            if (ix_data == OP_LOOP) depth_d = depth_q - A_ONE;
            if (ix_data == OP_END)  depth_d = depth_q + A_ONE;
            if (pc_q == '0) begin
              pc_d  = ret_q;
              fault = FC_SCAN_BOF;
            end else begin
              pc_d = pc_q - A_ONE;
            end
          end
        end
      end
`endif

      IN_WAIT: begin
        if (in_valid) begin
          dt_d     = in_data;
          dt_we    = 1'b1;
          dt_wdata = in_data;
          state_d  = FETCH;
        end
      end

      OUT_WAIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = FETCH;
        end
      end

      default: ; // HALT, FAULT hold until reset
    endcase

    if (fault != FC_NONE) state_d = FAULT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RESET_LOAD;
      pc_q        <= '0;
      dc_q        <= DC_BASE;
      dt_q        <= '0;
      depth_q     <= '0;
      ph_q        <= 1'b0;
      refill_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifndef BF_LOOP_STACK_EN
      ret_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      dc_q        <= dc_d;
      dt_q        <= dt_d;
      depth_q     <= depth_d;
      ph_q        <= ph_d;
      refill_q    <= refill_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifndef BF_LOOP_STACK_EN
      ret_q       <= ret_d;
`endif
    end
  end

  assign ix_addr   = pc_q;
  assign dt_addr   = dc_q;
  assign in_ready  = (state_q == IN_WAIT);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign pcout     = pc_q;
  assign dcout     = dc_q;
  assign halted    = (state_q == HALT) || (state_q == FAULT);
  assign error     = (state_q == FAULT);

endmodule

// File: doc/bf_core.md
# bf_core

Parametrised Brainfuck execution core and the next generation of the bfX datapath. It executes the full eight-instruction set, including `[`/`]` loops through a hardware return stack, and `.`/`,` through valid/ready byte streams. It drives separate instruction-read and data-read/write memory ports. Cell width, address width and loop depth are parameters, and faults are reported rather than silently ignored.

## Interface
- `DATA_W`, default 8: cell width in bits.
- `ADDR_W`, default 16: width of the program counter and data pointer.
- `STACK_DEPTH`, default 16: number of nested loops the return stack can hold.
- `DC_BASE`, default 16'h0100: data pointer value after reset.
- `clk`  in  1  the single clock.
- `rst`  in  1  synchronous, active-high reset.
- `ix_addr`  out  ADDR_W  instruction fetch address.
- `ix_data`  in  8  instruction byte; valid one cycle after `ix_addr`.
- `dt_addr`  out  ADDR_W  data address; always equals `dc`.
- `dt_we`  out  1  data write strobe.
- `dt_wdata`  out  DATA_W  data write value.
- `dt_rdata`  in  DATA_W  data read value; valid one cycle after `dt_addr`.
- `in_data`  in  DATA_W  input stream data.
- `in_valid`  in  1  input stream valid.
- `in_ready`  out  1  input stream ready.
- `out_data`  out  DATA_W  output stream data.
- `out_valid`  out  1  output stream valid.
- `out_ready`  in  1  output stream ready.
- `pcout`, `dcout`  out  ADDR_W  debug copies of `pc` and `dc`.
- `halted`  out  1  high once the core has stopped.
- `error`  out  1  high if the stop was caused by a fault.

## Operation
- Opcodes are ASCII:
  - `+` 0x2B and `-` 0x2D add or subtract 1 from the cell, modulo 2^DATA_W.
  - `>` 0x3E and `<` 0x3C add or subtract 1 from `dc`, modulo 2^ADDR_W.
  - `.` 0x2E outputs the cell; `,` 0x2C reads a byte into the cell.
  - `[` 0x5B and `]` 0x5D are loop brackets.
  - 0x00 halts.
  - Any other byte is a NOP.
- Cell cache: `dt` holds the current cell. `+`, `-` and `,` update `dt` and write it through with `dt_we`=1 for one cycle.
- Pointer moves (`<`, `>`) pass through the LOAD state, which refills `dt` from `dt_rdata`.
- `[`:
  - dt≠0: push the address of the `[` onto the stack.
  - dt==0: enter SKIP. SKIP fetches forward with a depth counter (`[` increments, `]` decrements). It resumes at the instruction after the `]` that brings the depth to 0.
- `]`:
  - dt≠0: `pc` ← top+1; the stack is unchanged.
  - dt==0: pop and continue.
- FSM states: RESET_LOAD, FETCH, EXEC, LOAD, SKIP, IN_WAIT, OUT_WAIT, HALT, FAULT.
  - RESET_LOAD performs the initial cell read at DC_BASE, then goes to FETCH.
  - HALT and FAULT are absorbing until `rst`.
- Faults, each ending with `halted`=`error`=1 and `pc` frozen at the offending instruction:
  - push when the stack is full;
  - `]` with an empty stack;
  - reaching 0x00 while in SKIP.
- `pc` wraps from 2^ADDR_W−1 to 0.

## Timing
- Reset values:
  - `pc`=0, `dc`=DC_BASE, `dt`=0;
  - `halted`, `error`, `dt_we`, `in_ready`, `out_valid` all 0;
  - `out_data`=0, `ix_addr`=0, stack empty.
- Reset asserted in any state returns all of the above on the next edge. Any pending stream handshake is abandoned.
- Cycle counts:
  - `+`, `-`, NOP, `[`, `]`: 2 cycles (FETCH, EXEC).
  - `<`, `>`: 3 cycles (LOAD added).
  - Each SKIP byte: 2 cycles.
- `.`: `out_valid`=1 with `out_data`=`dt` from the cycle after EXEC. Both hold stable until the cycle where `out_valid`&&`out_ready`, then FETCH follows.
- `,`: `in_ready`=1 in IN_WAIT. The core captures on `in_valid`&&`in_ready`, writes memory in the same cycle, then goes to FETCH.
- `dt_we` is never asserted in the same cycle as a pointer change.

## Configuration
- `BF_LOOP_STACK_EN` defined: the return stack is instantiated.
  - Backward `]` jump takes 1 cycle.
  - Overflow and underflow faults apply.
- `BF_LOOP_STACK_EN` undefined: no stack.
  - `[` with dt≠0 just advances.
  - `]` with dt≠0 enters a SCAN_BACK state that walks `pc` backwards with a depth counter, at 2 cycles per byte.
  - Walking past address 0 is a fault.
  - `STACK_DEPTH` is ignored.

## Structure
- Package `bf_pkg`: opcode localparams, state enum, fault cause codes.
- Sub-module `bf_loop_stack`: parametrised depth and width, with push/pop/top/full/empty. It is instantiated only under `BF_LOOP_STACK_EN`.
- The SKIP depth counter is ADDR_W bits wide.

## Test plan
- Program "+++.",0x00 → exactly one output transfer of 0x03, then `halted`=1, `error`=0.
- "+++[->+<]>.",0x00 → output 0x03; memory at 0x0100 = 0x00 and at 0x0101 = 0x03.
- "[[+]+]+.",0x00 with cell 0 → nested brackets skipped, output 0x01.
- "-.",0x00 with DATA_W=8 → output 0xFF. Separately, DC_BASE=0 with "<" → `dcout`=0xFFFF.
- STACK_DEPTH=2, "+[[[" → `error`=1, `halted`=1, `pcout`=3. Separately, "]" → `error`=1, `pcout`=0.
- "," with `in_valid` delayed 5 cycles and `in_data`=0x41, then "." with `out_ready` low for 3 cycles → `out_data`=0x41 held stable. `rst` pulsed during OUT_WAIT → `out_valid`=0 and `pcout`=0 on the next cycle.
